// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable counter: operating mode encoding.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP    = 2'b00,
    MODE_DOWN  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

endpackage

// File: rtl/prog_counter.sv
// General-purpose up/down/shift-fill counter with load, wrap-or-saturate limits,
// terminal-count pulse, compare match and sticky overflow flag.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] compare_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             match,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic             ovf_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             tc_nxt_s;
  logic             ovf_set_s;
  mode_e            mode_s;

  assign count = count_r;
  assign tc    = tc_r;
  assign ovf   = ovf_r;
  assign match = (count_r == compare_value);

  // Next-state decision: load beats counting; boundary events raise tc and ovf_set.
  always_comb begin
    count_nxt_s = count_r;
    tc_nxt_s    = 1'b0;
    ovf_set_s   = 1'b0;
    mode_s      = mode_e'(mode);
    if (load) begin
      count_nxt_s = load_value;
    end else if (en) begin
      case (mode_s)
        MODE_UP: begin
          if (count_r == ALL_ONES) begin
            tc_nxt_s  = 1'b1;
            ovf_set_s = 1'b1;
            if (SATURATE) begin
              count_nxt_s = ALL_ONES;
            end else begin
              count_nxt_s = ZERO;
            end
          end else begin
            count_nxt_s = count_r + ONE;
          end
        end
        MODE_DOWN: begin
          if (count_r == ZERO) begin
            tc_nxt_s  = 1'b1;
            ovf_set_s = 1'b1;
            if (SATURATE) begin
              count_nxt_s = ZERO;
            end else begin
              count_nxt_s = ALL_ONES;
            end
          end else begin
            count_nxt_s = count_r - ONE;
          end
        end
        MODE_SHIFT: begin
          // Fill indicator: the saturation of a full register is the terminal event.
          count_nxt_s = {count_r[WIDTH-2:0], 1'b1};
          if (count_r == ALL_ONES) begin
            tc_nxt_s = 1'b1;
          end else begin
            tc_nxt_s = 1'b0;
          end
        end
        MODE_HOLD: begin
          count_nxt_s = count_r;
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State register; an overflow set in the same cycle as clear_ovf wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= ZERO;
      tc_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      tc_r    <= tc_nxt_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clear_ovf) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

endmodule
